voice_mixer: RTL and testbench

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/voice_mixer_pkg.sv | 29 ++
 rtl/voice_mixer_sat_round.sv | 42 ++++
 rtl/voice_mixer.sv | 138 +++++++++++++
 tb/tb_voice_mixer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/voice_mixer_pkg.sv
// rtl/voice_mixer_pkg.sv - shared defaults, FSM encoding, gain shift and clog2 for the voice mixer
package voice_mixer_pkg;

    localparam int BITDEPTH_DEFAULT = 14;
    localparam int NVOICES_DEFAULT  = 4;

    // volume is a fixed-point gain with 7 fractional bits: 128 means unity
    localparam int GAIN_SHIFT = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/voice_mixer_sat_round.sv
// rtl/voice_mixer_sat_round.sv - gain shift, saturation and offset-binary conversion of the mix sum
//
// Purely combinational.
//   i_acc     signed accumulated sum of (sample x volume) products
//   o_sample  offset-binary sample for the DAC
//   o_clip    the shifted sum fell outside the signed BITDEPTH range
module sat_round
    import voice_mixer_pkg::*;
#(
    parameter int BITDEPTH = BITDEPTH_DEFAULT,
    parameter int ACCW     = BITDEPTH + 8
) (
    input  logic signed [ACCW-1:0]     i_acc,
    output logic        [BITDEPTH-1:0] o_sample,
    output logic                       o_clip
);

    localparam logic signed [ACCW-1:0] MAX_VAL = {{(ACCW-BITDEPTH+1){1'b0}}, {(BITDEPTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MIN_VAL = {{(ACCW-BITDEPTH+1){1'b1}}, {(BITDEPTH-1){1'b0}}};

    logic signed [ACCW-1:0]     w_shifted;
    logic        [BITDEPTH-1:0] w_sat;

    // arithmetic shift rounds toward minus infinity (floor)
    assign w_shifted = i_acc >>> GAIN_SHIFT;

    always_comb begin
        o_clip = 1'b0;
        w_sat  = w_shifted[BITDEPTH-1:0];
        if (w_shifted > MAX_VAL) begin
            w_sat  = {1'b0, {(BITDEPTH-1){1'b1}}};
            o_clip = 1'b1;
        end else if (w_shifted < MIN_VAL) begin
            w_sat  = {1'b1, {(BITDEPTH-1){1'b0}}};
            o_clip = 1'b1;
        end
    end

    // two's complement to offset-binary: flip the sign bit
    assign o_sample = {~w_sat[BITDEPTH-1], w_sat[BITDEPTH-2:0]};

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - sequential per-voice gain mixer producing one offset-binary DAC sample per sample_clock edge
//
// Ports:
//   clk, resetn    system clock, synchronous active-low reset
//   sample_clock   sample-rate strobe, rising edge starts a mix
//   voice_in       NVOICES signed BITDEPTH-bit samples, voice i at [i*BITDEPTH +: BITDEPTH]
//   volume         NVOICES unsigned 8-bit gains, voice i at [i*8 +: 8], 128 = unity
//   out            mixed sample, offset-binary, held between updates
//   out_valid      one-clk pulse when out updates
//   clip           that sample saturated; held until the next out_valid
//   overrun        sticky; an edge arrived while a mix was in progress
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int BITDEPTH = BITDEPTH_DEFAULT,
    parameter int NVOICES  = NVOICES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          sample_clock,
    input  logic [NVOICES*BITDEPTH-1:0]   voice_in,
    input  logic [NVOICES*8-1:0]          volume,
    output logic [BITDEPTH-1:0]           out,
    output logic                          out_valid,
    output logic                          clip,
    output logic                          overrun
);

    localparam int CNTW = (NVOICES > 1) ? clog2(NVOICES) : 1;
    // full-precision sum: BITDEPTH x 8-bit magnitude, plus growth for NVOICES terms
    localparam int ACCW = BITDEPTH + 8 + clog2(NVOICES);

    state_t r_state;
    state_t w_next;

    logic                       r_sc_q;
    logic        [CNTW-1:0]     r_cnt;
    logic signed [ACCW-1:0]     r_acc;
    logic signed [BITDEPTH-1:0] r_voice [NVOICES];
    logic        [7:0]          r_vol   [NVOICES];
    logic        [BITDEPTH-1:0] r_out;
    logic                       r_valid;
    logic                       r_clip;
    logic                       r_overrun;

    logic                       w_edge;
    logic                       w_last;
    logic signed [ACCW-1:0]     w_prod;
    logic        [BITDEPTH-1:0] w_sat_sample;
    logic                       w_sat_clip;

    assign w_edge = sample_clock & ~r_sc_q;
    assign w_last = (r_cnt == CNTW'(NVOICES - 1));

    // volume is zero-extended so it multiplies as a non-negative signed value
    assign w_prod = ACCW'(r_voice[r_cnt]) * ACCW'($signed({1'b0, r_vol[r_cnt]}));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_edge) w_next = ST_ACCUM;
            ST_ACCUM:  if (w_last) w_next = ST_OUTPUT;
            ST_OUTPUT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // sc_q resets high so a strobe already high at release is not an edge
            r_sc_q    <= 1'b1;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_out     <= {1'b1, {(BITDEPTH-1){1'b0}}};
            r_valid   <= 1'b0;
            r_clip    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NVOICES; i++) begin
                r_voice[i] <= '0;
                r_vol[i]   <= '0;
            end
        end else begin
            r_sc_q  <= sample_clock;
            r_valid <= 1'b0;

            // edges outside IDLE (including the OUTPUT->IDLE cycle) are dropped
            if (w_edge && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        for (int i = 0; i < NVOICES; i++) begin
                            r_voice[i] <= voice_in[i*BITDEPTH +: BITDEPTH];
                            r_vol[i]   <= volume[i*8 +: 8];
                        end
                    end
                end
                ST_ACCUM: begin
                    r_acc <= r_acc + w_prod;
                    r_cnt <= r_cnt + CNTW'(1);
                end
                ST_OUTPUT: begin
                    r_out   <= w_sat_sample;
                    r_clip  <= w_sat_clip;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    sat_round #(
        .BITDEPTH (BITDEPTH),
        .ACCW     (ACCW)
    ) u_sat_round (
        .i_acc    (r_acc),
        .o_sample (w_sat_sample),
        .o_clip   (w_sat_clip)
    );

    assign out       = r_out;
    assign out_valid = r_valid;
    assign clip      = r_clip;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - directed self-checking bench for voice_mixer
`timescale 1ns/1ps
module tb_voice_mixer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sample_clock;
    logic [55:0] voice_in;
    logic [31:0] volume;
    logic [13:0] out;
    logic        out_valid;
    logic        clip;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    always #62.5 clk = ~clk;

    voice_mixer dut (
        .clk          (clk),
        .resetn       (resetn),
        .sample_clock (sample_clock),
        .voice_in     (voice_in),
        .volume       (volume),
        .out          (out),
        .out_valid    (out_valid),
        .clip         (clip),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] pack_v(input int a, input int b, input int c, input int d);
        return {d[13:0], c[13:0], b[13:0], a[13:0]};
    endfunction

    function automatic logic [31:0] pack_g(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Starts a mix at edge k, then checks out_valid after edges k..k+11.
    // Inputs are scrambled after k+1; ovr_j >= 0 injects a second edge at k+ovr_j+1;
    // rst_j >= 0 applies reset at edge k+rst_j+1.
    task automatic run_mix(input string tag, input logic [55:0] v, input logic [31:0] g,
                           input logic [13:0] exp_out, input logic exp_clip,
                           input int ovr_j, input int rst_j);
        logic exp_v;
        @(negedge clk) sample_clock = 1'b0;
        @(negedge clk) begin
            voice_in     = v;
            volume       = g;
            sample_clock = 1'b1;
        end
        @(posedge clk);
        for (int j = 0; j <= 11; j++) begin
            @(negedge clk);
            exp_v = (rst_j < 0) && (j == 5);
            check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v) begin
                check({tag, "_out"}, {18'd0, out}, {18'd0, exp_out});
                check({tag, "_clip"}, {31'd0, clip}, {31'd0, exp_clip});
            end
            if (j == 1) begin
                voice_in = ~v;
                volume   = ~g;
            end
            if (ovr_j >= 0 && j == ovr_j - 1) sample_clock = 1'b0;
            if (ovr_j >= 0 && j == ovr_j) sample_clock = 1'b1;
            if (rst_j >= 0 && j == rst_j) resetn = 1'b0;
            if (rst_j >= 0 && j == rst_j + 1) resetn = 1'b1;
        end
        if (rst_j >= 0) begin
            check({tag, "_out_reset"}, {18'd0, out}, 32'h2000);
            check({tag, "_clip_reset"}, {31'd0, clip}, 32'd0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk) resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn       = 1'b0;
        sample_clock = 1'b1;
        voice_in     = '0;
        volume       = '0;
        repeat (2) @(negedge clk);
        check("rst_out", {18'd0, out}, 32'h2000);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_clip", {31'd0, clip}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rel_no_valid", {31'd0, out_valid}, 32'd0);
        end

        run_mix("unity", pack_v(1000, 0, 0, 0), pack_g(128, 0, 0, 0), 14'h23E8, 1'b0, -1, -1);
        run_mix("sat_hi", pack_v(8191, 8191, 8191, 8191), pack_g(255, 255, 255, 255), 14'h3FFF, 1'b1, -1, -1);
        run_mix("sat_lo", pack_v(-8192, -8192, -8192, -8192), pack_g(255, 255, 255, 255), 14'h0000, 1'b1, -1, -1);
        run_mix("floor", pack_v(-3, 0, 0, 0), pack_g(64, 0, 0, 0), 14'd8190, 1'b0, -1, -1);
        run_mix("multi", pack_v(100, 200, -300, 400), pack_g(128, 64, 255, 0), 14'd7794, 1'b0, -1, -1);
        check("no_overrun", {31'd0, overrun}, 32'd0);

        // edge landing in the OUTPUT->IDLE cycle
        run_mix("ovr_out", pack_v(1000, 0, 0, 0), pack_g(128, 0, 0, 0), 14'h23E8, 1'b0, 4, -1);
        check("ovr_out_flag", {31'd0, overrun}, 32'd1);

        apply_reset();
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        run_mix("ovr_acc", pack_v(1000, 0, 0, 0), pack_g(128, 0, 0, 0), 14'h23E8, 1'b0, 1, -1);
        check("ovr_acc_flag", {31'd0, overrun}, 32'd1);
        run_mix("after_ovr", pack_v(-3, 0, 0, 0), pack_g(64, 0, 0, 0), 14'd8190, 1'b0, -1, -1);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        run_mix("rst_mid", pack_v(1000, 0, 0, 0), pack_g(128, 0, 0, 0), 14'h23E8, 1'b0, -1, 2);
        check("rst_mid_overrun", {31'd0, overrun}, 32'd0);
        run_mix("post_rst", pack_v(100, 200, -300, 400), pack_g(128, 64, 255, 0), 14'd7794, 1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
